pwm_multi: RTL

Multi-channel PWM generator with one shared period counter and independent per-channel duty and polarity. It offers edge- or center-aligned counting, a programmable clock prescaler, and glitch-free shadow-register updates applied only at period boundaries. It sits between the button/register control logic and the output pins, and is the parametrised successor of the single-channel 8-bit PWM.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_multi.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block.
package pwm_pkg;

  // Counting mode of the shared period counter
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Supported parameter ranges
  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 16;
  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 16;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits one tick every prescale+1 enabled clk cycles.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] r_pcnt;

  // Count 0..prescale; also folds back to 0 if prescale shrank below pcnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (!en || (r_pcnt >= prescale)) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRE_WIDTH'(1);
    end
  end

  assign tick = en && (r_pcnt == prescale);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center counter, shadowed period/duty/pol.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRE_WIDTH-1:0]      prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      center,
  input  logic [CHANNELS-1:0]       pol,
  input  logic                      upd,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      cycle_end,
  output logic                      upd_pending
);

  logic                      w_tick;
  logic                      w_boundary;
  logic                      w_apply;
  logic [WIDTH-1:0]          w_cnt_inc;
  logic [WIDTH-1:0]          w_cnt_dec;
  logic [CHANNELS-1:0]       w_raw;

  logic [WIDTH-1:0]          r_cnt;
  logic                      r_dir_down;

  logic [WIDTH-1:0]          r_period_a;
  logic [CHANNELS*WIDTH-1:0] r_duty_a;
  pwm_mode_e                 r_mode_a;
  logic [CHANNELS-1:0]       r_pol_a;

  logic [WIDTH-1:0]          r_period_s;
  logic [CHANNELS*WIDTH-1:0] r_duty_s;
  pwm_mode_e                 r_mode_s;
  logic [CHANNELS-1:0]       r_pol_s;
  logic                      r_pending;

  logic [CHANNELS-1:0]       r_pwm;
  logic                      r_cycle_end;

  pwm_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .tick     (w_tick)
  );

  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_cnt_dec = r_cnt - WIDTH'(1);

  // Period boundary: the tick that returns cnt to its start value
  assign w_boundary = w_tick &&
                      ((r_mode_a == MODE_CENTER)
                         ? ((r_period_a == '0) || (r_dir_down && (r_cnt == WIDTH'(1))))
                         : (r_cnt == r_period_a));

  // Shadow moves to active at a boundary, or immediately while disabled
  assign w_apply = r_pending && (w_boundary || !en);

  // Shared period counter with up/down direction for center mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (!en || w_apply) begin
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (w_tick) begin
      if (r_mode_a == MODE_EDGE) begin
        r_cnt      <= (r_cnt == r_period_a) ? '0 : w_cnt_inc;
        r_dir_down <= 1'b0;
      end else if (w_boundary) begin
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
      end else if (!r_dir_down) begin
        r_cnt      <= w_cnt_inc;
        r_dir_down <= (w_cnt_inc == r_period_a);
      end else begin
        r_cnt      <= w_cnt_dec;
      end
    end
  end

  // Shadow capture on upd, shadow-to-active transfer on apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_s <= '0;
      r_duty_s   <= '0;
      r_mode_s   <= MODE_EDGE;
      r_pol_s    <= '0;
      r_period_a <= '0;
      r_duty_a   <= '0;
      r_mode_a   <= MODE_EDGE;
      r_pol_a    <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_apply) begin
        r_period_a <= r_period_s;
        r_duty_a   <= r_duty_s;
        r_mode_a   <= r_mode_s;
        r_pol_a    <= r_pol_s;
      end
      if (upd) begin
        r_period_s <= period;
        r_duty_s   <= duty;
        r_mode_s   <= center ? MODE_CENTER : MODE_EDGE;
        r_pol_s    <= pol;
        r_pending  <= 1'b1;
      end else if (w_apply) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // Per-channel compare against the shared counter
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
    assign w_raw[g] = (r_cnt < r_duty_a[g*WIDTH +: WIDTH]);
  end

  // Registered outputs; idle level is the active polarity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm       <= '0;
      r_cycle_end <= 1'b0;
    end else begin
      r_pwm       <= en ? (w_raw ^ r_pol_a) : r_pol_a;
      r_cycle_end <= w_boundary;
    end
  end

  assign pwm_out     = r_pwm;
  assign cycle_end   = r_cycle_end;
  assign upd_pending = r_pending;

endmodule
